// File: rtl/scroll_pkg.sv
// rtl/scroll_pkg.sv - shared types and constants for the scroll motion controller
package scroll_pkg;

    typedef enum logic [1:0] {SM_FREEZE, SM_BOUNCE, SM_WRAP, SM_MANUAL} scroll_mode_t;

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} fsm_state_t;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // wide enough for MIN_SPEED (<=127) plus up to 6 random bits
    localparam int SPD_W = 8;

endpackage

// File: rtl/scroll_axis_step.sv
// rtl/scroll_axis_step.sv - combinational next position/dir/speed for one axis of one layer
module scroll_axis_step
    import scroll_pkg::*;
#(
    parameter int POS_W     = 14,
    parameter int MIN_SPEED = 2
) (
    input  logic [POS_W-1:0] pos,
    input  logic [POS_W-1:0] bmp,
    input  logic [POS_W-1:0] disp,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic [SPD_W-1:0] spd,
    input  logic             pend_v,
    input  logic [POS_W-1:0] pend,
    input  logic             pause,
    input  logic [SPD_W-1:0] rnd_lo,
    input  logic [SPD_W-1:0] rnd_hi,
    output logic [POS_W-1:0] pos_nxt,
    output logic             dir_nxt,
    output logic [SPD_W-1:0] spd_nxt
);
    localparam int W = POS_W + 2;
    localparam logic [SPD_W-1:0] MIN_SPD = SPD_W'(MIN_SPEED);

    logic signed [W-1:0] pos_s, bmp_s, disp_s, spd_s, pend_s;
    logic signed [W-1:0] lim, sum, dec, pos_r;

    always_comb begin
        pos_s  = signed'({2'b00, pos});
        bmp_s  = signed'({2'b00, bmp});
        disp_s = signed'({2'b00, disp});
        pend_s = signed'({2'b00, pend});
        spd_s  = signed'(W'(spd));
        lim    = bmp_s - disp_s;
        if (lim < 0) begin
            lim = '0;
        end
        sum     = pos_s + spd_s;
        dec     = pos_s - spd_s;
        pos_r   = pos_s;
        dir_nxt = dir;
        spd_nxt = spd;
        if (pend_v) begin
            if (mode == SM_WRAP) begin
                pos_r = (bmp_s == 0) ? '0 : ((pend_s >= bmp_s) ? pend_s - bmp_s : pend_s);
            end else begin
                pos_r = (pend_s > lim) ? lim : pend_s;
            end
        end else if (!pause) begin
            case (mode)
                SM_BOUNCE: begin
                    // edges clamp exactly to 0/lim and reload a random speed
                    if (!dir) begin
                        if (sum >= lim) begin
                            pos_r   = lim;
                            dir_nxt = 1'b1;
                            spd_nxt = MIN_SPD + rnd_lo;
                        end else begin
                            pos_r = sum;
                        end
                    end else if (dec <= 0) begin
                        pos_r   = '0;
                        dir_nxt = 1'b0;
                        spd_nxt = MIN_SPD + rnd_hi;
                    end else begin
                        pos_r = dec;
                    end
                end
                SM_WRAP: begin
                    pos_r = (bmp_s == 0) ? '0 : ((sum >= bmp_s) ? sum - bmp_s : sum);
                end
                default: ;
            endcase
        end
        pos_nxt = pos_r[POS_W-1:0];
    end

endmodule

// File: rtl/scroll_motion_ctrl.sv
// rtl/scroll_motion_ctrl.sv - per-layer X/Y viewport offset generator, updated once per video frame
module scroll_motion_ctrl
    import scroll_pkg::*;
#(
    parameter int          LAYERS     = 2,
    parameter int          POS_W      = 14,
    parameter int          SPEED_BITS = 2,
    parameter int          MIN_SPEED  = 2,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                      CLK_IN,
    input  logic                      reset,
    input  logic                      vid_xena,
    input  logic                      vid_yena,
    input  logic [LAYERS*POS_W-1:0]   bmp_w,
    input  logic [LAYERS*POS_W-1:0]   bmp_h,
    input  logic [POS_W-1:0]          disp_w,
    input  logic [POS_W-1:0]          disp_h,
    input  logic [LAYERS*2-1:0]       mode,
    input  logic                      pause,
    input  logic [LAYERS-1:0]         load_stb,
    input  logic [POS_W-1:0]          load_x,
    input  logic [POS_W-1:0]          load_y,
    output logic [LAYERS*POS_W-1:0]   xpos,
    output logic [LAYERS*POS_W-1:0]   ypos,
    output logic                      frame_tick,
    output logic                      upd_done,
    output logic                      overrun
);
    localparam int IW = (LAYERS > 1) ? $clog2(LAYERS) : 1;
    localparam logic [15:0]      RND_MASK = 16'((1 << SPEED_BITS) - 1);
    localparam logic [SPD_W-1:0] MIN_SPD  = SPD_W'(MIN_SPEED);

    logic [1:0]        xsync, ysync;
    logic              xena_d, yena_snap, hs;
    logic [15:0]       lfsr;
    fsm_state_t        state;
    logic [IW-1:0]     idx;

    logic [POS_W-1:0]  pos_x  [LAYERS];
    logic [POS_W-1:0]  pos_y  [LAYERS];
    logic [POS_W-1:0]  pend_x [LAYERS];
    logic [POS_W-1:0]  pend_y [LAYERS];
    logic [SPD_W-1:0]  spd_x  [LAYERS];
    logic [SPD_W-1:0]  spd_y  [LAYERS];
    logic [LAYERS-1:0] dir_x, dir_y, pend_v;

    logic [SPD_W-1:0]  rnd_lo, rnd_hi, nx_spd_x, nx_spd_y;
    logic [POS_W-1:0]  nx_pos_x, nx_pos_y;
    logic              nx_dir_x, nx_dir_y;

    assign hs     = xsync[1] & ~xena_d;
    assign rnd_lo = SPD_W'(lfsr & RND_MASK);
    assign rnd_hi = SPD_W'((lfsr >> SPEED_BITS) & RND_MASK);

    // one step unit per axis, time-shared across layers by idx
    scroll_axis_step #(.POS_W(POS_W), .MIN_SPEED(MIN_SPEED)) u_step_x (
        .pos(pos_x[idx]), .bmp(bmp_w[int'(idx)*POS_W +: POS_W]), .disp(disp_w),
        .mode(mode[int'(idx)*2 +: 2]), .dir(dir_x[idx]), .spd(spd_x[idx]),
        .pend_v(pend_v[idx]), .pend(pend_x[idx]), .pause(pause),
        .rnd_lo(rnd_lo), .rnd_hi(rnd_hi),
        .pos_nxt(nx_pos_x), .dir_nxt(nx_dir_x), .spd_nxt(nx_spd_x)
    );

    scroll_axis_step #(.POS_W(POS_W), .MIN_SPEED(MIN_SPEED)) u_step_y (
        .pos(pos_y[idx]), .bmp(bmp_h[int'(idx)*POS_W +: POS_W]), .disp(disp_h),
        .mode(mode[int'(idx)*2 +: 2]), .dir(dir_y[idx]), .spd(spd_y[idx]),
        .pend_v(pend_v[idx]), .pend(pend_y[idx]), .pause(pause),
        .rnd_lo(rnd_lo), .rnd_hi(rnd_hi),
        .pos_nxt(nx_pos_y), .dir_nxt(nx_dir_y), .spd_nxt(nx_spd_y)
    );

    always_ff @(posedge CLK_IN) begin
        if (reset) begin
            xsync      <= '0;
            ysync      <= '0;
            xena_d     <= 1'b0;
            yena_snap  <= 1'b0;
            frame_tick <= 1'b0;
            lfsr       <= LFSR_SEED;
            state      <= ST_IDLE;
            idx        <= '0;
            upd_done   <= 1'b0;
            overrun    <= 1'b0;
            pend_v     <= '0;
            dir_x      <= '0;
            dir_y      <= '0;
            for (int l = 0; l < LAYERS; l++) begin
                pos_x[l]  <= '0;
                pos_y[l]  <= '0;
                pend_x[l] <= '0;
                pend_y[l] <= '0;
                spd_x[l]  <= MIN_SPD;
                spd_y[l]  <= MIN_SPD;
            end
        end else begin
            xsync  <= {xsync[0], vid_xena};
            ysync  <= {ysync[0], vid_yena};
            xena_d <= xsync[1];
            if (hs) begin
                yena_snap <= ysync[1];
            end
            // frame end = first line start after yena has dropped
            frame_tick <= hs & yena_snap & ~ysync[1];
            lfsr       <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
            upd_done   <= 1'b0;
            if (frame_tick && state != ST_IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (frame_tick) begin
                        state <= ST_CALC;
                        idx   <= '0;
                    end
                end
                ST_CALC: begin
                    pos_x[idx]  <= nx_pos_x;
                    pos_y[idx]  <= nx_pos_y;
                    dir_x[idx]  <= nx_dir_x;
                    dir_y[idx]  <= nx_dir_y;
                    spd_x[idx]  <= nx_spd_x;
                    spd_y[idx]  <= nx_spd_y;
                    pend_v[idx] <= 1'b0;
                    if (idx == IW'(LAYERS - 1)) begin
                        state    <= ST_DONE;
                        upd_done <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
            // a strobe landing in the same cycle as its layer's CALC stays pending
            for (int l = 0; l < LAYERS; l++) begin
                if (load_stb[l]) begin
                    pend_x[l] <= load_x;
                    pend_y[l] <= load_y;
                    pend_v[l] <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < LAYERS; g++) begin : g_out
        assign xpos[g*POS_W +: POS_W] = pos_x[g];
        assign ypos[g*POS_W +: POS_W] = pos_y[g];
    end

endmodule

// File: tb/tb_scroll_motion_ctrl.sv
// tb/tb_scroll_motion_ctrl.sv - scoreboard bench for scroll_motion_ctrl
`timescale 1ns/1ps
module tb_scroll_motion_ctrl;
    localparam int L  = 8;
    localparam int PW = 14;

    logic clk = 1'b0, vclk = 1'b0;
    logic reset = 1'b1, xena = 1'b0, yena = 1'b0, pause = 1'b0;
    logic [L*PW-1:0] bmp_w = '0, bmp_h = '0, xpos, ypos;
    logic [PW-1:0]   disp_w = 14'd1920, disp_h = 14'd1080, load_x = '0, load_y = '0;
    logic [L*2-1:0]  mode = '0;
    logic [L-1:0]    load_stb = '0;
    logic            frame_tick, upd_done, overrun;

    typedef struct {
        int frame;
        int layer;
        bit axis;
        int lo;
        int hi;
    } exp_t;
    exp_t sb[$];

    int n_pass = 0, n_total = 0;
    int frame_no = 0, upd_cnt = 0, tick_cnt = 0, cyc = 0, tick_cyc = 0;
    bit lat_en = 1'b1;

    always #5 clk = ~clk;
    always #3.367 vclk = ~vclk;

    scroll_motion_ctrl #(.LAYERS(L), .POS_W(PW), .SPEED_BITS(2), .MIN_SPEED(2), .LFSR_SEED(16'hACE1)) dut (
        .CLK_IN(clk), .reset(reset), .vid_xena(xena), .vid_yena(yena),
        .bmp_w(bmp_w), .bmp_h(bmp_h), .disp_w(disp_w), .disp_h(disp_h),
        .mode(mode), .pause(pause), .load_stb(load_stb), .load_x(load_x), .load_y(load_y),
        .xpos(xpos), .ypos(ypos), .frame_tick(frame_tick), .upd_done(upd_done), .overrun(overrun)
    );

    task automatic check_rng(input string nm, input int act, input int lo, input int hi);
        n_total++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    endtask

    function automatic int get_pos(input bit ax, input int l);
        logic [PW-1:0] v;
        v = ax ? ypos[l*PW +: PW] : xpos[l*PW +: PW];
        return int'(v);
    endfunction

    task automatic expect_pos(input int l, input bit ax, input int lo, input int hi);
        exp_t e;
        e.frame = frame_no; e.layer = l; e.axis = ax; e.lo = lo; e.hi = hi;
        sb.push_back(e);
    endtask

    task automatic set_layer(input int l, input int bw, input int bh, input int m);
        bmp_w[l*PW +: PW] = PW'(bw);
        bmp_h[l*PW +: PW] = PW'(bh);
        mode[l*2 +: 2]    = 2'(m);
    endtask

    task automatic load(input int l, input int x, input int y);
        @(negedge clk);
        load_x = PW'(x); load_y = PW'(y); load_stb[l] = 1'b1;
        @(negedge clk);
        load_stb = '0;
    endtask

    task automatic do_frame();
        int t;
        yena = 1'b1; repeat (4) @(negedge clk);
        xena = 1'b1; repeat (3) @(negedge clk);
        xena = 1'b0; repeat (3) @(negedge clk);
        yena = 1'b0; repeat (4) @(negedge clk);
        xena = 1'b1; repeat (3) @(negedge clk);
        xena = 1'b0;
        t = 0;
        while (upd_cnt < frame_no && t < 40) begin @(negedge clk); t++; end
        if (upd_cnt < frame_no) check_rng("frame_timeout", upd_cnt, frame_no, frame_no);
    endtask

    task automatic vid_frame();
        for (int ln = 0; ln < 6; ln++) begin
            yena = (ln < 4);
            repeat (10) @(negedge vclk);
            xena = 1'b1;
            repeat (20) @(negedge vclk);
            xena = 1'b0;
        end
    endtask

    // monitor: counts ticks, checks latency, drains scoreboard on each upd_done
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (frame_tick) begin tick_cnt++; tick_cyc = cyc; end
        if (upd_done) begin
            upd_cnt++;
            if (lat_en) check_rng("upd_latency", cyc - tick_cyc, L + 1, L + 1);
            while (sb.size() > 0 && sb[0].frame <= upd_cnt) begin
                e = sb.pop_front();
                check_rng($sformatf("%s%0d_f%0d", e.axis ? "ypos" : "xpos", e.layer, e.frame),
                          get_pos(e.axis, e.layer), e.lo, e.hi);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, tb0, ub0;
        bit [1:0] ov_seq [8];
        ov_seq = '{2'b01, 2'b11, 2'b01, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_rng("reset_xpos_nz", int'(|xpos), 0, 0);
        check_rng("reset_ypos_nz", int'(|ypos), 0, 0);
        check_rng("reset_frame_tick", int'(frame_tick), 0, 0);
        check_rng("reset_upd_done", int'(upd_done), 0, 0);
        check_rng("reset_overrun", int'(overrun), 0, 0);

        // bounce: lim = 2000-1920 = 80, speed 2 from reset
        set_layer(0, 2000, 0, 1);
        for (int k = 1; k <= 41; k++) begin
            frame_no++;
            if (k <= 39)      expect_pos(0, 0, 2 * k, 2 * k);
            else if (k == 40) expect_pos(0, 0, 80, 80);
            else              expect_pos(0, 0, 75, 78);
            expect_pos(0, 1, 0, 0);
            expect_pos(1, 0, 0, 0);
            do_frame();
        end

        // reset in the CALC cycle of layer 0
        yena = 1'b1; repeat (4) @(negedge clk);
        xena = 1'b1; repeat (3) @(negedge clk);
        xena = 1'b0; repeat (3) @(negedge clk);
        yena = 1'b0; repeat (4) @(negedge clk);
        xena = 1'b1;
        t = 0;
        while (!frame_tick && t < 20) begin @(negedge clk); t++; end
        check_rng("midcalc_tick_seen", int'(frame_tick), 1, 1);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0; xena = 1'b0; mode = '0;
        repeat (20) @(negedge clk);
        check_rng("midcalc_xpos_nz", int'(|xpos), 0, 0);
        check_rng("midcalc_ypos_nz", int'(|ypos), 0, 0);
        check_rng("midcalc_no_upd", upd_cnt, frame_no, frame_no);

        // wrap on layer 1
        set_layer(0, 2000, 1090, 0);
        set_layer(1, 100, 100, 2);
        load(1, 99, 10);
        frame_no++; expect_pos(1, 0, 99, 99); expect_pos(1, 1, 10, 10); expect_pos(0, 0, 0, 0); do_frame();
        frame_no++; expect_pos(1, 0, 1, 1);   expect_pos(1, 1, 12, 12); do_frame();
        frame_no++; expect_pos(1, 0, 3, 3);   expect_pos(1, 1, 14, 14); do_frame();

        // manual + pause; layer 0 bounce with lim 80 / 10, loads last-wins
        set_layer(0, 2000, 1090, 1);
        set_layer(1, 100, 1280, 3);
        pause = 1'b1;
        load(0, 60, 9);
        load(0, 30, 7);
        load(1, 40, 5000);
        for (int k = 0; k < 2; k++) begin
            frame_no++;
            expect_pos(0, 0, 30, 30); expect_pos(0, 1, 7, 7);
            expect_pos(1, 0, 0, 0);   expect_pos(1, 1, 200, 200);
            do_frame();
        end
        pause = 1'b0;
        frame_no++; expect_pos(0, 0, 32, 32); expect_pos(0, 1, 9, 9);  expect_pos(1, 1, 200, 200); do_frame();
        frame_no++; expect_pos(0, 0, 34, 34); expect_pos(0, 1, 10, 10); expect_pos(1, 1, 200, 200); do_frame();
        frame_no++; expect_pos(0, 0, 36, 36); expect_pos(0, 1, 5, 8);   expect_pos(1, 0, 0, 0);     do_frame();

        // back-to-back frame ends: second tick lands in CALC
        mode = '0;
        check_rng("overrun_before", int'(overrun), 0, 0);
        lat_en = 1'b0;
        tb0 = tick_cnt;
        frame_no++;
        for (int s = 0; s < 8; s++) begin
            xena = ov_seq[s][1]; yena = ov_seq[s][0];
            repeat ((s == 0) ? 4 : 2) @(negedge clk);
        end
        xena = 1'b0;
        repeat (30) @(negedge clk);
        check_rng("overrun_ticks", tick_cnt - tb0, 2, 2);
        check_rng("overrun_one_upd", upd_cnt, frame_no, frame_no);
        check_rng("overrun_set", int'(overrun), 1, 1);
        lat_en = 1'b1;
        frame_no++; expect_pos(0, 0, 36, 36); do_frame();
        check_rng("overrun_sticky", int'(overrun), 1, 1);

        // asynchronous video timing from an unrelated 148.5 MHz clock
        tb0 = tick_cnt; ub0 = upd_cnt;
        for (int f = 0; f < 100; f++) begin
            frame_no++;
            vid_frame();
        end
        repeat (40) @(negedge clk);
        check_rng("sync_ticks", tick_cnt - tb0, 100, 100);
        check_rng("sync_upds", upd_cnt - ub0, 100, 100);
        check_rng("sync_overrun_sticky", int'(overrun), 1, 1);
        check_rng("sb_drained", sb.size(), 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
